tri_bus_arbiter: RTL and testbench
==================================

// Module: tri_bus_arbiter
//
// PURPOSE
// Upstream control stage for the shared single-bit tri-state bus. Arbitrates
// two requesters (A, B) and generates the drive_a/value_a/drive_b/value_b
// enables consumed by the bus driver stage. Round-robin on ties, bounded
// ownership under contention, and enforced all-released turnaround cycles,
// so the two drive enables are never asserted together (no bus conflict).
//
// PARAMETERS
// TURN_CYCLES  1  cycles with both drives low between owners; legal range >= 1
// MAX_HOLD     8  cycles an owner keeps the bus while the other requests; >= 1
//
// PORTS
// clk        in   1  system clock, rising edge
// rst        in   1  synchronous reset, active-high
// req_a      in   1  A requests bus ownership (level)
// data_a     in   1  bit A drives while granted
// req_b      in   1  B requests bus ownership (level)
// data_b     in   1  bit B drives while granted
// drive_a    out  1  A drive enable (registered)
// value_a    out  1  data_a when drive_a, else 0
// drive_b    out  1  B drive enable (registered)
// value_b    out  1  data_b when drive_b, else 0
// turn       out  1  1 while in turnaround (bus released)
// idle       out  1  1 in IDLE (no owner, no turnaround)
//
// BEHAVIOUR
// - States: IDLE, OWN_A, OWN_B, TURN. Outputs decode from registered state:
//   drive_a = (OWN_A), drive_b = (OWN_B), turn = (TURN), idle = (IDLE).
// - Reset: state IDLE; drive_a = drive_b = 0, value_a = value_b = 0, turn = 0,
//   idle = 1; hold_cnt = turn_cnt = 0; last_owner = B, so A wins the first tie.
// - Pick rule: only one requester -> that one; both -> not last_owner.
// - IDLE: any req -> OWN_<pick> next cycle (grant latency 1 cycle, no turnaround
//   out of IDLE). No req -> stay IDLE.
// - OWN_X: on entry hold_cnt = 0, last_owner = X. hold_cnt increments each
//   cycle and saturates at MAX_HOLD-1. Exit to TURN next cycle when:
//   (a) req_X = 0, or (b) the other requests and hold_cnt == MAX_HOLD-1
//   (preemption). If only X requests, X holds the bus indefinitely.
// - TURN: both drives low for exactly TURN_CYCLES cycles (turn_cnt 0..TURN_CYCLES-1).
//   On the last cycle, apply the pick rule to the current reqs: -> OWN_<pick>,
//   or IDLE if no req. The previous owner can regain the bus only when the
//   other is not requesting.
// - Requests that drop before being served are forgotten; there is no queue.
// - Invariant: drive_a & drive_b == 0 on every cycle, including during reset.
// - rst mid-ownership: both drives drop on the next clock edge and arbitration
//   restarts from IDLE with last_owner = B.
// - Counters sized $clog2 of parameter + 1; no wrap-around, only saturation.
//
// TESTING
// 1 rst high 2 cycles -> drive_a=drive_b=0, idle=1, turn=0.
// 2 req_a=1 alone, data_a toggling -> drive_a=1 one cycle later; value_a tracks
//   data_a; drop req_a -> TURN 1 cycle (TURN_CYCLES=1) -> IDLE.
// 3 req_a=req_b=1 in the same cycle after reset -> A owns the bus; B gets it
//   after 8 A cycles + 1 turnaround; then A after 8 B cycles (round-robin).
// 4 B owns, req_b drops while req_a=1 -> exactly TURN_CYCLES cycles with both
//   drives low, then drive_a=1; repeat with TURN_CYCLES=3 -> 3-cycle gap.
// 5 A owns with req_b=0 for 50 cycles -> drive_a held continuously, no TURN.
// 6 rst asserted mid-OWN_B -> drive_b=0 on the next edge; random reqs for 10k
//   cycles -> assert !(drive_a && drive_b) on every cycle.

Source files
------------

// File: rtl/tri_bus_arbiter_if.sv
// tri_bus_arbiter_if
// Purpose: groups the request/data inputs and the drive/value/status outputs
// of the two-requester tri-state bus arbiter.
// Signals:
//   req_a, data_a, req_b, data_b : requester side -> arbiter
//   drive_a, value_a             : A drive enable and gated drive value
//   drive_b, value_b             : B drive enable and gated drive value
//   turn                         : bus released for turnaround
//   idle                         : no owner, no turnaround
// Modports: master = requester/driver side, slave = arbiter side.
interface tri_bus_arbiter_if;
  logic req_a;
  logic data_a;
  logic req_b;
  logic data_b;
  logic drive_a;
  logic value_a;
  logic drive_b;
  logic value_b;
  logic turn;
  logic idle;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  drive_a, value_a, drive_b, value_b, turn, idle
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output drive_a, value_a, drive_b, value_b, turn, idle
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
// Purpose: arbitrates two requesters onto a shared single-bit tri-state bus.
// Round-robin on ties, ownership bounded to MAX_HOLD cycles under contention,
// and TURN_CYCLES all-released cycles between owners so both drive enables
// are never high together.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : tri_bus_arbiter_if.slave (requests/data in, drives/status out)
// Parameters:
//   TURN_CYCLES : cycles with both drives low between owners (>= 1)
//   MAX_HOLD    : cycles an owner keeps the bus while the other requests (>= 1)
//
// state  | meaning
// IDLE   | no owner, bus released
// OWN_A  | A drives the bus
// OWN_B  | B drives the bus
// TURN   | turnaround, bus released between owners
module tri_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic           clk,
  input  logic           rst,
  tri_bus_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam int TW = $clog2(TURN_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [HW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [TW-1:0]   r_turn_cnt, w_turn_nxt;
  logic            r_last_b, w_last_b_nxt;   // 1: B owned last
  logic            w_any_req;
  logic            w_pick_b;

  assign w_any_req = bus.req_a | bus.req_b;
  // B wins if it is the only requester, or on a tie when A owned last.
  assign w_pick_b  = bus.req_b & (~bus.req_a | ~r_last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_turn_cnt <= '0;
      r_last_b   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_last_b   <= w_last_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_turn_nxt   = r_turn_cnt;
    w_last_b_nxt = r_last_b;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = w_pick_b ? OWN_B : OWN_A;
          w_hold_nxt   = '0;
          w_last_b_nxt = w_pick_b;
        end
      end
      OWN_A: begin
        if (!bus.req_a || (bus.req_b && r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = TURN;
          w_turn_nxt  = '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!bus.req_b || (bus.req_a && r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = TURN;
          w_turn_nxt  = '0;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (r_turn_cnt == TURN_LAST) begin
          if (w_any_req) begin
            w_state_nxt  = w_pick_b ? OWN_B : OWN_A;
            w_hold_nxt   = '0;
            w_last_b_nxt = w_pick_b;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_turn_nxt = r_turn_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.drive_a = (r_state == OWN_A);
  assign bus.drive_b = (r_state == OWN_B);
  assign bus.value_a = (r_state == OWN_A) & bus.data_a;
  assign bus.value_b = (r_state == OWN_B) & bus.data_b;
  assign bus.turn    = (r_state == TURN);
  assign bus.idle    = (r_state == IDLE);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb_tri_bus_arbiter
// Purpose: self-checking bench for tri_bus_arbiter. Two instances run side by
// side on the same stimulus (TURN_CYCLES = 1 and 3) and are compared each
// cycle against a bench-side ownership model.
module tb_tri_bus_arbiter;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tri_bus_arbiter_if bus1 ();
  tri_bus_arbiter_if bus3 ();

  tri_bus_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(MH)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  tri_bus_arbiter #(.TURN_CYCLES(3), .MAX_HOLD(MH)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who holds the bus (0 none, 1 A, 2 B, 3 gap), how many cycles the
  // current owner has held it, how many gap cycles have elapsed, last owner.
  int m_who[2];
  int m_held[2];
  int m_gap[2];
  int m_last[2];
  int m_tc[2] = '{1, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit ra, input bit rb, input int last);
    if (ra && !rb) return 1;
    if (rb && !ra) return 2;
    return (last == 1) ? 2 : 1;
  endfunction

  task automatic model_step(input int k, input bit ra, input bit rb, input bit rs);
    bit mine, other;
    if (rs) begin
      m_who[k] = 0; m_held[k] = 0; m_gap[k] = 0; m_last[k] = 2;
      return;
    end
    case (m_who[k])
      0: if (ra || rb) begin
        m_who[k] = pick(ra, rb, m_last[k]); m_last[k] = m_who[k]; m_held[k] = 1;
      end
      1, 2: begin
        mine  = (m_who[k] == 1) ? ra : rb;
        other = (m_who[k] == 1) ? rb : ra;
        if (!mine || (other && m_held[k] >= MH)) begin
          m_who[k] = 3; m_gap[k] = 1;
        end else if (m_held[k] < MH) begin
          m_held[k]++;
        end
      end
      default: begin
        if (m_gap[k] >= m_tc[k]) begin
          if (ra || rb) begin
            m_who[k] = pick(ra, rb, m_last[k]); m_last[k] = m_who[k]; m_held[k] = 1;
          end else begin
            m_who[k] = 0;
          end
        end else begin
          m_gap[k]++;
        end
      end
    endcase
  endtask

  function automatic logic [5:0] model_out(input int k, input bit da, input bit db);
    bit a, b;
    a = (m_who[k] == 1);
    b = (m_who[k] == 2);
    return {a, a & da, b, b & db, m_who[k] == 3, m_who[k] == 0};
  endfunction

  // One clock: drive inputs, step the model at the edge, compare #1 later.
  task automatic tick(input bit ra, input bit da, input bit rb, input bit db, input bit rs);
    rst = rs;
    bus1.req_a = ra; bus1.data_a = da; bus1.req_b = rb; bus1.data_b = db;
    bus3.req_a = ra; bus3.data_a = da; bus3.req_b = rb; bus3.data_b = db;
    @(posedge clk);
    model_step(0, ra, rb, rs);
    model_step(1, ra, rb, rs);
    #1;
    check("dut1_outs", {26'd0, bus1.drive_a, bus1.value_a, bus1.drive_b, bus1.value_b,
          bus1.turn, bus1.idle}, {26'd0, model_out(0, da, db)});
    check("dut3_outs", {26'd0, bus3.drive_a, bus3.value_a, bus3.drive_b, bus3.value_b,
          bus3.turn, bus3.idle}, {26'd0, model_out(1, da, db)});
    check("excl1", {31'd0, bus1.drive_a & bus1.drive_b}, 32'd0);
    check("excl3", {31'd0, bus3.drive_a & bus3.drive_b}, 32'd0);
  endtask

  initial begin
    int g1, g3, na;
    bit s1, s3, saw_turn, ra, rb;

    // 1: reset
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    check("rst_idle", {31'd0, bus1.idle}, 32'd1);
    check("rst_turn", {31'd0, bus1.turn}, 32'd0);
    check("rst_drv",  {30'd0, bus1.drive_a, bus1.drive_b}, 32'd0);

    // 2: A alone, data toggling, then release
    tick(1, 1, 0, 0, 0);
    check("grant_a", {31'd0, bus1.drive_a}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(1, i[0], 0, 0, 0);
      check("value_a", {31'd0, bus1.value_a}, {31'd0, i[0]});
    end
    tick(0, 0, 0, 0, 0);
    check("rel_turn", {31'd0, bus1.turn}, 32'd1);
    tick(0, 0, 0, 0, 0);
    check("rel_idle", {31'd0, bus1.idle}, 32'd1);

    // 3: simultaneous requests after reset, round-robin with preemption
    tick(0, 0, 0, 0, 1);
    for (int c = 1; c <= 19; c++) begin
      tick(1, 1, 1, 1, 0);
      if (c == 8)  check("rr_a_last", {31'd0, bus1.drive_a}, 32'd1);
      if (c == 9)  check("rr_turn1",  {31'd0, bus1.turn},    32'd1);
      if (c == 10) check("rr_b_first",{31'd0, bus1.drive_b}, 32'd1);
      if (c == 17) check("rr_b_last", {31'd0, bus1.drive_b}, 32'd1);
      if (c == 18) check("rr_turn2",  {31'd0, bus1.turn},    32'd1);
      if (c == 19) check("rr_a_again",{31'd0, bus1.drive_a}, 32'd1);
    end

    // 4: B owns, drops while A requests -> gap length equals TURN_CYCLES
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0);
    check("b_owns", {30'd0, bus1.drive_b, bus3.drive_b}, 32'd3);
    g1 = 0; g3 = 0; s1 = 0; s3 = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0, 0, 0);
      if (bus1.drive_a) s1 = 1;
      if (bus3.drive_a) s3 = 1;
      if (!s1 && !bus1.drive_a && !bus1.drive_b) g1++;
      if (!s3 && !bus3.drive_a && !bus3.drive_b) g3++;
    end
    check("gap1_len", g1, 1);
    check("gap3_len", g3, 3);
    check("gap_done", {30'd0, s1, s3}, 32'd3);

    // 5: A alone for 50 cycles holds continuously
    na = 0; saw_turn = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1, i[1], 0, 0, 0);
      if (bus1.drive_a) na++;
      if (bus1.turn) saw_turn = 1;
    end
    check("hold50", na, 50);
    check("hold_noturn", {31'd0, saw_turn}, 32'd0);

    // 6: reset mid-OWN_B, then random traffic
    tick(0, 0, 1, 1, 1);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    check("pre_rst_b", {31'd0, bus1.drive_b}, 32'd1);
    tick(0, 0, 1, 1, 1);
    check("rst_drop_b", {30'd0, bus1.drive_b, bus3.drive_b}, 32'd0);
    ra = 0; rb = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) ra = ~ra;
      if ($urandom_range(0, 7) == 0) rb = ~rb;
      tick(ra, 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)),
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
